// File: rtl/md_unit_pkg.sv
// Shared types for the E-stage multiply/divide unit.
// Opcodes, FSM states and the arithmetic result bundle.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } md_res_t;

  function automatic logic is_long_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_arith.sv
// Combinational datapath: (op, a, b) -> {hi, lo, div0}.
// One multiplier and one magnitude divider serve both signednesses.
module md_arith
  import md_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_res_t     res
);

  logic        mul_s;
  logic        div_s;
  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] prod;
  logic [31:0] na;
  logic [31:0] nb;
  logic [31:0] dv;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] qs;
  logic [31:0] rs;
  logic        div0;

  // Sign-extend for MULT so the low 64 bits of the product are exact.
  always_comb begin
    mul_s = (op == MD_MULT);
    ma    = mul_s ? {{32{a[31]}}, a} : {32'b0, a};
    mb    = mul_s ? {{32{b[31]}}, b} : {32'b0, b};
    prod  = ma * mb;
  end

  // Divide magnitudes, then restore signs; quotient truncates to zero.
  always_comb begin
    div_s = (op == MD_DIV);
    na    = (div_s && a[31]) ? -a : a;
    nb    = (div_s && b[31]) ? -b : b;
    div0  = (b == 32'd0);
    dv    = div0 ? 32'd1 : nb;
    q     = na / dv;
    r     = na % dv;
    qs    = (div_s && (a[31] ^ b[31])) ? -q : q;
    rs    = (div_s && a[31]) ? -r : r;
  end

  // Select the result bundle for the requested operation.
  always_comb begin
    res = '0;
    unique case (1'b1)
      (op == MD_MULT),
      (op == MD_MULTU): begin
        res.hi = prod[63:32];
        res.lo = prod[31:0];
      end
      is_div_op(op): begin
        res.hi   = rs;
        res.lo   = qs;
        res.div0 = div0;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO owner with a busy counter modelling mult/div latency.
// Results are computed at accept and committed when the count ends.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  md_op_e     op;
  md_res_t    res;

  md_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_res_t    pend_q, pend_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  assign op = md_op_e'(MdOp);

  md_arith u_arith (
    .op  (op),
    .a   (A),
    .b   (B),
    .res (res)
  );

  // Next-state: accept in IDLE, count down in RUN, commit at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          unique case (1'b1)
            is_long_op(op): begin
              pend_d  = res;
              state_d = ST_RUN;
              cnt_d   = is_div_op(op) ?
                        CNT_W'(DIV_CYCLES - 1) :
                        CNT_W'(MULT_CYCLES - 1);
            end
            (op == MD_MTHI): hi_d = A;
            (op == MD_MTLO): lo_d = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (!pend_q.div0) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
